led_pattern_ctrl: RTL and testbench
===================================

// Module: led_pattern_ctrl
//
// PURPOSE
//   Parametrised successor to the static LED on/off driver for the Red Pitaya LED bank.
//   Each of LED_WIDTH channels has its own mode: OFF, ON, BLINK, or PWM dimming.
//   Software programs channels one at a time through a single-cycle config write.
//   A shared blink prescaler and a shared PWM counter produce the timing.
//   Sits between the housekeeping register bank and the led_o pins.
//
// PARAMETERS
//   LED_WIDTH   8           number of LED channels (1..16)
//   PWM_BITS    8           PWM counter / duty width
//   BLINK_HALF  62_500_000  cycles per blink half-period (0.5 s @125 MHz); >=2
//   CNT_BITS    27          blink prescaler width; must hold BLINK_HALF-1
//   CH_BITS     3           channel index width; 2**CH_BITS >= LED_WIDTH
//
// PORTS
//   clk_i       in   1          system clock
//   rstn_i      in   1          async active-low reset
//   cfg_we_i    in   1          config write strobe, one cycle
//   cfg_ch_i    in   CH_BITS    target channel index
//   cfg_mode_i  in   2          00 OFF, 01 ON, 10 BLINK, 11 PWM
//   cfg_duty_i  in   PWM_BITS   PWM duty; stored on every accepted write
//   sync_i      in   1          restart blink and PWM timing
//   cfg_ack_o   out  1          one-cycle pulse: write accepted
//   cfg_err_o   out  1          one-cycle pulse: write rejected (bad channel)
//   led_o       out  LED_WIDTH  registered LED drive, 1 = lit
//
// BEHAVIOUR
//   Reset (rstn_i low, async): all outputs go to 0 immediately.
//   - All modes OFF, all duties 0.
//   - blink_cnt=0, blink_ph=0, pwm_cnt=0.
//   - A reset mid-blink or mid-PWM discards all state; nothing is retained.
//
//   Config write at edge N with cfg_we_i=1:
//   - If cfg_ch_i < LED_WIDTH: mode[ch] and duty[ch] load at edge N, and cfg_ack_o=1 during N..N+1.
//   - Otherwise: no register changes, and cfg_err_o=1 during N..N+1.
//   - Back-to-back writes give one ack/err pulse per write cycle.
//   - Two writes to the same channel: the last one wins.
//
//   PWM counter:
//   - pwm_cnt free-runs 0 .. 2**PWM_BITS-1 and wraps to 0.
//   - PWM output is (pwm_cnt < duty): duty 0 = never lit; duty 2**PWM_BITS-1 = lit 255 of 256 cycles.
//
//   Blink prescaler:
//   - blink_cnt counts 0 .. BLINK_HALF-1.
//   - At terminal count it wraps to 0 and blink_ph toggles.
//   - Period = 2*BLINK_HALF cycles; phase is shared by all channels.
//
//   sync_i at edge N:
//   - blink_cnt, pwm_cnt and blink_ph are all cleared to 0.
//   - sync wins over a simultaneous terminal count or wrap.
//   - A write in the same cycle still takes effect.
//
//   led_o[i] is registered from the current mode[i] and timing state:
//   - OFF -> 0, ON -> 1, BLINK -> blink_ph, PWM -> (pwm_cnt < duty[i]).
//   - Latency: a write at edge N changes led_o at edge N+1.
//   - A mode change mid-period takes effect at edge N+1; no waiting for a period boundary.
//
// TESTING (sim with BLINK_HALF=4, PWM_BITS=4, LED_WIDTH=8)
//   1. Reset: assert rstn_i mid-run with ch0=ON.
//      -> led_o=0 and ack=0 the same delta; all state stays 0 after release.
//   2. Write ch3 mode=01 at edge N.
//      -> cfg_ack_o=1 for one cycle; led_o=8'h08 from edge N+1; other bits stay 0.
//   3. Write ch0 mode=10, then hold.
//      -> led_o[0] stays low 4 cycles, high 4 cycles, low 4 cycles (period 8).
//      -> sync_i mid-high forces led_o[0] low one edge later.
//   4. Write ch1 mode=11, duty=4.
//      -> led_o[1] is high 4 of every 16 cycles.
//      -> duty=0 gives always 0; duty=15 gives 15 of 16 cycles high.
//   5. Write cfg_ch_i=9.
//      -> cfg_err_o pulses once, cfg_ack_o stays 0, no led_o change.
//      -> Back-to-back writes to ch2 then ch5 give two ack pulses and both LEDs updated.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: per-channel LED driver (OFF / ON / BLINK / PWM).
// Software writes one channel per cycle; a shared blink prescaler and a shared
// PWM counter provide the timing for every channel. led_o is registered.

// One LED channel: holds its mode/duty and produces the registered drive bit.
module led_lane #(
    parameter int PWM_BITS = 8
) (
    input  logic                gclk,
    input  logic                grst_n,
    input  logic                we,
    input  logic [1:0]          mode_in,
    input  logic [PWM_BITS-1:0] duty_in,
    input  logic                blink_ph,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    typedef enum logic [1:0] {
        M_OFF   = 2'b00,
        M_ON    = 2'b01,
        M_BLINK = 2'b10,
        M_PWM   = 2'b11
    } mode_t;

    mode_t               mode;
    logic [PWM_BITS-1:0] duty;

    // Channel configuration; mode and duty are always loaded together.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            mode <= M_OFF;
            duty <= '0;
        end else if (we) begin
            mode <= mode_t'(mode_in);
            duty <= duty_in;
        end
    end

    // Drive bit follows the stored mode immediately, no period alignment.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            led <= 1'b0;
        end else begin
            case (mode)
                M_OFF:   led <= 1'b0;
                M_ON:    led <= 1'b1;
                M_BLINK: led <= blink_ph;
                M_PWM:   led <= (pwm_cnt < duty);
                default: led <= 1'b0;
            endcase
        end
    end

endmodule

module led_pattern_ctrl #(
    parameter int LED_WIDTH  = 8,
    parameter int PWM_BITS   = 8,
    parameter int BLINK_HALF = 62_500_000,
    parameter int CNT_BITS   = 27,
    parameter int CH_BITS    = 3
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 cfg_we_i,
    input  logic [CH_BITS-1:0]   cfg_ch_i,
    input  logic [1:0]           cfg_mode_i,
    input  logic [PWM_BITS-1:0]  cfg_duty_i,
    input  logic                 sync_i,
    output logic                 cfg_ack_o,
    output logic                 cfg_err_o,
    output logic [LED_WIDTH-1:0] led_o
);

    // One extra bit so LED_WIDTH == 2**CH_BITS is still representable.
    localparam logic [CH_BITS:0]    NUM_CH   = (CH_BITS+1)'(LED_WIDTH);
    localparam logic [CNT_BITS-1:0] BLINK_TC = CNT_BITS'(BLINK_HALF - 1);

    logic [CNT_BITS-1:0]  blink_cnt;
    logic                 blink_ph;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic                 ch_ok;
    logic [LED_WIDTH-1:0] lane_we;

    assign ch_ok = ({1'b0, cfg_ch_i} < NUM_CH);

    // Blink prescaler: phase toggles every BLINK_HALF cycles; sync restarts it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (sync_i) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLINK_TC) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Free-running PWM counter, wraps naturally at 2**PWM_BITS.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pwm_cnt <= '0;
        end else if (sync_i) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Write handshake: one ack or err pulse per write strobe.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cfg_ack_o <= 1'b0;
            cfg_err_o <= 1'b0;
        end else begin
            cfg_ack_o <= cfg_we_i && ch_ok;
            cfg_err_o <= cfg_we_i && !ch_ok;
        end
    end

    for (genvar i = 0; i < LED_WIDTH; i++) begin : g_lane
        assign lane_we[i] = cfg_we_i && ch_ok && (cfg_ch_i == CH_BITS'(i));

        led_lane #(
            .PWM_BITS (PWM_BITS)
        ) u_lane (
            .gclk     (clk_i),
            .grst_n   (rstn_i),
            .we       (lane_we[i]),
            .mode_in  (cfg_mode_i),
            .duty_in  (cfg_duty_i),
            .blink_ph (blink_ph),
            .pwm_cnt  (pwm_cnt),
            .led      (led_o[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a time-based model.
module tb_led_pattern_ctrl;

    localparam int LW  = 8;
    localparam int PB  = 4;
    localparam int BH  = 4;
    localparam int CB  = 2;
    localparam int CHB = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic           we = 1'b0;
    logic [CHB-1:0] ch = '0;
    logic [1:0]     mode = '0;
    logic [PB-1:0]  duty = '0;
    logic           sync = 1'b0;
    logic           ack;
    logic           err;
    logic [LW-1:0]  led;

    int checks = 0;
    int passed = 0;

    led_pattern_ctrl #(
        .LED_WIDTH  (LW),
        .PWM_BITS   (PB),
        .BLINK_HALF (BH),
        .CNT_BITS   (CB),
        .CH_BITS    (CHB)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .cfg_we_i   (we),
        .cfg_ch_i   (ch),
        .cfg_mode_i (mode),
        .cfg_duty_i (duty),
        .sync_i     (sync),
        .cfg_ack_o  (ack),
        .cfg_err_o  (err),
        .led_o      (led)
    );

    always #5 clk = ~clk;

    // Model: t = cycles since reset/sync; blink phase and PWM count derive from t.
    int          t = 0;
    int          m_mode[LW];
    int          m_duty[LW];
    logic [LW-1:0] e_led = '0;
    logic        e_ack = 1'b0;
    logic        e_err = 1'b0;

    initial begin
        for (int i = 0; i < LW; i++) begin
            m_mode[i] = 0;
            m_duty[i] = 0;
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t = 0;
            for (int i = 0; i < LW; i++) begin
                m_mode[i] = 0;
                m_duty[i] = 0;
            end
            e_led = '0;
            e_ack = 1'b0;
            e_err = 1'b0;
        end else begin
            for (int i = 0; i < LW; i++) begin
                case (m_mode[i])
                    1:       e_led[i] = 1'b1;
                    2:       e_led[i] = ((t / BH) % 2) == 1;
                    3:       e_led[i] = (t % (1 << PB)) < m_duty[i];
                    default: e_led[i] = 1'b0;
                endcase
            end
            e_ack = we && (int'(ch) < LW);
            e_err = we && !(int'(ch) < LW);
            if (e_ack) begin
                m_mode[int'(ch)] = int'(mode);
                m_duty[int'(ch)] = int'(duty);
            end
            t = sync ? 0 : t + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock cycle: drive at negedge, compare everything at the next negedge.
    task automatic step(input logic w, input int c, input int md, input int dt, input logic s);
        logic [31:0] cv;
        logic [31:0] mv;
        logic [31:0] dv;
        cv = c;
        mv = md;
        dv = dt;
        we   = w;
        ch   = cv[CHB-1:0];
        mode = mv[1:0];
        duty = dv[PB-1:0];
        sync = s;
        @(posedge clk);
        @(negedge clk);
        we   = 1'b0;
        sync = 1'b0;
        chk("ack", {31'd0, ack}, {31'd0, e_ack});
        chk("err", {31'd0, err}, {31'd0, e_err});
        chk("led", {24'd0, led}, {24'd0, e_led});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0, 1'b0);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic mid_reset(input string tag);
        #2 rstn = 1'b0;
        #1;
        chk({tag, "_led0"}, {24'd0, led}, 32'd0);
        chk({tag, "_ack0"}, {31'd0, ack}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [11:0]   seq;
        logic [LW-1:0] prev;
        int            cnt;

        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk("rst_led", {24'd0, led}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);

        // 1. reset mid-run with ch0 ON and an ack in flight
        step(1'b1, 0, 1, 0, 1'b0);
        idle(1);
        chk("t1_on", {31'd0, led[0]}, 32'd1);
        step(1'b1, 3, 1, 0, 1'b0);
        chk("t1_ack_pre", {31'd0, ack}, 32'd1);
        mid_reset("t1");
        idle(3);
        chk("t1_post", {24'd0, led}, 32'd0);

        // 2. ch3 ON
        step(1'b1, 3, 1, 0, 1'b0);
        chk("t2_ack", {31'd0, ack}, 32'd1);
        chk("t2_led_lat", {24'd0, led}, 32'd0);
        idle(1);
        chk("t2_ack_off", {31'd0, ack}, 32'd0);
        chk("t2_led", {24'd0, led}, 32'h08);

        // 3. ch0 BLINK, timing restarted by sync on the same write
        step(1'b1, 0, 2, 0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            idle(1);
            seq[k] = led[0];
        end
        chk("t3_blink_seq", {20'd0, seq}, 32'h0F0);
        idle(1);
        chk("t3_high", {31'd0, led[0]}, 32'd1);
        step(1'b0, 0, 0, 0, 1'b1);
        chk("t3_sync_edge", {31'd0, led[0]}, 32'd1);
        idle(1);
        chk("t3_sync_low", {31'd0, led[0]}, 32'd0);
        chk("t3_ch3", {31'd0, led[3]}, 32'd1);

        // 4. ch1 PWM duty 4 / 0 / 15 over a full 16-cycle period
        step(1'b1, 1, 3, 4, 1'b1);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            idle(1);
            cnt += int'(led[1]);
        end
        chk("t4_duty4", cnt, 4);
        step(1'b1, 1, 3, 0, 1'b0);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            idle(1);
            cnt += int'(led[1]);
        end
        chk("t4_duty0", cnt, 0);
        step(1'b1, 1, 3, 15, 1'b0);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            idle(1);
            cnt += int'(led[1]);
        end
        chk("t4_duty15", cnt, 15);

        // 5. bad channel, then back-to-back writes
        step(1'b1, 0, 0, 0, 1'b0);
        step(1'b1, 1, 0, 0, 1'b0);
        idle(1);
        prev = led;
        step(1'b1, 9, 1, 5, 1'b0);
        chk("t5_err", {31'd0, err}, 32'd1);
        chk("t5_noack", {31'd0, ack}, 32'd0);
        idle(1);
        chk("t5_err_off", {31'd0, err}, 32'd0);
        chk("t5_nochg", {24'd0, led}, {24'd0, prev});
        step(1'b1, 2, 1, 0, 1'b0);
        chk("t5_ack_a", {31'd0, ack}, 32'd1);
        step(1'b1, 5, 1, 0, 1'b0);
        chk("t5_ack_b", {31'd0, ack}, 32'd1);
        idle(1);
        chk("t5_led", {24'd0, led}, 32'h2C);

        // randomized traffic, including rare mid-cycle resets
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 3) == 0, int'($urandom % 16), int'($urandom % 4),
                 int'($urandom % 16), ($urandom % 25) == 0);
            if (($urandom % 400) == 0) mid_reset("rnd_rst");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
